pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Parametrised, elastic pipeline-stage register. It generalises the fixed EX/MEM latch into a reusable stage for any boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds valid/ready handshake, an optional skid entry for full throughput under back-pressure, synchronous flush, and guaranteed bubble (zeroed control) insertion.
- Keeps a saturating back-pressure cycle counter for performance debug.
- Control, payload and PC fields are separate so bubbles zero control only.

Parameters:
CTRL_W, 12, width of control bundle (LS_bit, Branch, MemtoReg, MemWrite, RegWrite, Jump, Ext_op, PctoReg, …)
DATA_W, 128, width of datapath payload (alu_out, regfile_out2, branch target, etc.)
PC_W, 32, width of carried PC+4 field
PC_RESET, 32'h0000_3004, out_pc value after reset
SKID, 1, 1 = two-entry elastic stage (registered in_ready); 0 = single entry, combinational in_ready
CNT_W, 16, width of stall counter

Ports:
clock  input  1  stage clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  upstream holds valid entry
in_ready  output  1  stage can accept this cycle
in_ctrl  input  CTRL_W  control bundle from upstream
in_data  input  DATA_W  payload from upstream
in_pc  input  PC_W  PC+4 from upstream
flush  input  1  synchronous kill of all held entries (branch/jump redirect)
out_valid  output  1  stage presents valid entry
out_ready  input  1  downstream accepts this cycle
out_ctrl  output  CTRL_W  control bundle; all-zero whenever out_valid=0
out_data  output  DATA_W  payload (don't-care when out_valid=0, but held)
out_pc  output  PC_W  PC+4 of presented entry
stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Handshake and reset:
  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
  - Upstream must hold inputs stable while in_valid & !in_ready. Downstream likewise sees stable outputs while out_valid & !out_ready.
  - Reset (async assert, sync release) sets: state EMPTY, out_valid=0, out_ctrl=0, out_data=0, out_pc=PC_RESET, skid contents 0, stall_cnt=0, in_ready=1 (SKID=1).
- SKID=1 state machine (main entry drives outputs; skid is the second entry):
  - EMPTY: in_fire -> MAIN (main <- inputs). Otherwise stay.
  - MAIN:
    - in_fire & out_fire -> MAIN (main <- inputs).
    - in_fire & !out_fire -> FULL (skid <- inputs).
    - !in_fire & out_fire -> EMPTY.
    - Otherwise hold.
  - FULL: in_ready=0.
    - out_fire -> MAIN (main <- skid).
    - Otherwise hold.
  - in_ready is registered and equals (next_state != FULL). It depends only on state, never combinationally on out_ready.
- SKID=0: single entry. in_ready = !out_valid | out_ready (combinational). On in_fire, main <- inputs. On out_fire without in_fire, the stage empties.
- Latency and ordering:
  - Latency is one cycle from in_fire to out_valid when the stage is empty.
  - Order is strict FIFO; no entry is dropped or duplicated except by flush.
  - Throughput is one entry per cycle when out_ready=1 continuously.
- Bubble rule: out_ctrl is forced to 0 whenever out_valid=0. An empty stage therefore never asserts Branch/Jump/RegWrite/MemWrite.
- Flush:
  - Flush in cycle N discards main and skid. out_valid=0 and out_ctrl=0 from N+1; state EMPTY; in_ready=1 at N+1.
  - Flush has priority over a simultaneous in_fire: that entry is dropped.
  - out_fire in the same cycle as flush still completes downstream; the flush does not retract it.
  - out_data and out_pc hold their last values on flush.
- stall_cnt:
  - Increments by 1 on each cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W−1 with no wrap.
  - Unaffected by flush; cleared only by reset.
- Reset asserted mid-operation clears everything immediately, regardless of clock. No partial entry survives.

Test Plan:
1. Reset, then release with no input -> out_valid=0, out_ctrl=0, out_pc=32'h0000_3004, in_ready=1, stall_cnt=0.
2. Stream 8 entries (in_pc=0x3000,0x3004,…) with out_ready=1 every cycle -> out_pc matches in order, exactly one cycle after each in_fire; in_ready never drops.
3. SKID=1: send A, B; hold out_ready=0 for 5 cycles.
   - Required: state FULL, in_ready=0 after B, C held off, out shows A, stall_cnt=5.
   - Then raise out_ready: outputs A, B, C in order with no loss.
4. Fill stage with two entries whose ctrl=12'hFFF, then assert flush one cycle.
   - Required: next cycle out_valid=0, out_ctrl=0, in_ready=1.
   - The in_valid entry presented in the flush cycle is never output.
5. SKID=0 build: out_ready=0 with entry held -> in_ready=0 the same cycle. Raising out_ready with in_valid=1 gives in_ready=1 combinationally and a back-to-back replace.
6. Force out_valid=1 and out_ready=0 for 2^CNT_W+10 cycles (CNT_W=4 build) -> stall_cnt stops at 15. Assert reset asynchronously mid-stall -> all outputs return to reset values before the next clock edge.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with valid/ready handshake, optional skid entry,
// synchronous flush with bubble (zeroed control) insertion and a saturating stall counter.
module pipe_stage_reg #(
    parameter int unsigned     CTRL_W   = 12,
    parameter int unsigned     DATA_W   = 128,
    parameter int unsigned     PC_W     = 32,
    parameter logic [PC_W-1:0] PC_RESET = 32'h0000_3004,
    parameter bit              SKID     = 1'b1,
    parameter int unsigned     CNT_W    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [PC_W-1:0]   out_pc,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_MAIN  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              in_ready_q;
    logic              in_fire;
    logic              out_fire;
    logic              load_main;
    logic              load_skid;
    logic              main_from_skid;
    logic              kill_ctrl;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [PC_W-1:0]   skid_pc;

    // Without a skid entry the stage may accept whenever its single entry leaves this cycle.
    assign in_ready = SKID ? in_ready_q : (!out_valid | out_ready);
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Next-state and datapath steering; flush overrides any acceptance.
    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        kill_ctrl      = 1'b0;
        if (flush) begin
            state_d   = ST_EMPTY;
            kill_ctrl = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d   = ST_MAIN;
                        load_main = 1'b1;
                    end
                end
                ST_MAIN: begin
                    if (in_fire && out_fire) begin
                        load_main = 1'b1;
                    end else if (in_fire) begin
                        state_d   = ST_FULL;
                        load_skid = 1'b1;
                    end else if (out_fire) begin
                        state_d   = ST_EMPTY;
                        kill_ctrl = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_d        = ST_MAIN;
                        main_from_skid = 1'b1;
                    end
                end
                default: begin
                    state_d   = ST_EMPTY;
                    kill_ctrl = 1'b1;
                end
            endcase
        end
    end

    // State plus the registered flags derived from the next state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            out_valid  <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            out_valid  <= (state_d != ST_EMPTY);
            in_ready_q <= (state_d != ST_FULL);
        end
    end

    // Main entry drives the outputs; only control is zeroed when it empties so data/pc hold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_ctrl <= '0;
            out_data <= '0;
            out_pc   <= PC_RESET;
        end else if (load_main) begin
            out_ctrl <= in_ctrl;
            out_data <= in_data;
            out_pc   <= in_pc;
        end else if (main_from_skid) begin
            out_ctrl <= skid_ctrl;
            out_data <= skid_data;
            out_pc   <= skid_pc;
        end else if (kill_ctrl) begin
            out_ctrl <= '0;
        end
    end

    // Second entry, filled only while the main entry is stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            skid_ctrl <= '0;
            skid_data <= '0;
            skid_pc   <= '0;
        end else if (load_skid) begin
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
            skid_pc   <= in_pc;
        end
    end

    // Back-pressure cycle counter, saturating, untouched by flush.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a default (skid) instance and a
// single-entry instance with a 4-bit stall counter, sharing clock and reset.
module tb_pipe_stage_reg;

    logic         clock;
    logic         reset;

    logic         a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
    logic [11:0]  a_in_ctrl, a_out_ctrl;
    logic [127:0] a_in_data, a_out_data;
    logic [31:0]  a_in_pc, a_out_pc;
    logic [15:0]  a_stall_cnt;

    logic         b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
    logic [11:0]  b_in_ctrl, b_out_ctrl;
    logic [127:0] b_in_data, b_out_data;
    logic [31:0]  b_in_pc, b_out_pc;
    logic [3:0]   b_stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    pipe_stage_reg u_dut_a (
        .clock(clock), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_ctrl(a_in_ctrl), .in_data(a_in_data), .in_pc(a_in_pc),
        .flush(a_flush),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_ctrl(a_out_ctrl), .out_data(a_out_data), .out_pc(a_out_pc),
        .stall_cnt(a_stall_cnt)
    );

    pipe_stage_reg #(.SKID(1'b0), .CNT_W(4)) u_dut_b (
        .clock(clock), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_ctrl(b_in_ctrl), .in_data(b_in_data), .in_pc(b_in_pc),
        .flush(b_flush),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_ctrl(b_out_ctrl), .out_data(b_out_data), .out_pc(b_out_pc),
        .stall_cnt(b_stall_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [127:0] mk_data(input logic [31:0] pc);
        return {pc, ~pc, pc ^ 32'hA5A5_A5A5, pc + 32'd1};
    endfunction

    task automatic drive_a(input logic v, input logic [11:0] c, input logic [31:0] pc);
        a_in_valid = v;
        a_in_ctrl  = c;
        a_in_pc    = pc;
        a_in_data  = mk_data(pc);
    endtask

    task automatic drive_b(input logic v, input logic [11:0] c, input logic [31:0] pc);
        b_in_valid = v;
        b_in_ctrl  = c;
        b_in_pc    = pc;
        b_in_data  = mk_data(pc);
    endtask

    initial begin
        reset = 1'b1;
        drive_a(1'b0, 12'h000, 32'h0);
        drive_b(1'b0, 12'h000, 32'h0);
        a_flush = 1'b0; a_out_ready = 1'b0;
        b_flush = 1'b0; b_out_ready = 1'b0;
        #12 reset = 1'b0;

        // Reset state
        tick();
        check("rst_valid", 128'(a_out_valid), 128'd0);
        check("rst_ctrl", 128'(a_out_ctrl), 128'd0);
        check("rst_pc", 128'(a_out_pc), 128'h3004);
        check("rst_data", a_out_data, 128'd0);
        check("rst_in_ready", 128'(a_in_ready), 128'd1);
        check("rst_stall", 128'(a_stall_cnt), 128'd0);
        check("rst_b_in_ready", 128'(b_in_ready), 128'd1);

        // Full-rate stream, one-cycle latency
        a_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_a(1'b1, 12'(i + 1), 32'h3000 + 32'(4 * i));
            #1;
            check("stream_in_ready", 128'(a_in_ready), 128'd1);
            tick();
            check("stream_valid", 128'(a_out_valid), 128'd1);
            check("stream_pc", 128'(a_out_pc), 128'(32'h3000 + 32'(4 * i)));
            check("stream_ctrl", 128'(a_out_ctrl), 128'(i + 1));
            check("stream_data", a_out_data, mk_data(32'h3000 + 32'(4 * i)));
        end
        drive_a(1'b0, 12'h000, 32'h0);
        tick();
        check("drain_valid", 128'(a_out_valid), 128'd0);
        check("drain_bubble_ctrl", 128'(a_out_ctrl), 128'd0);
        check("drain_pc_held", 128'(a_out_pc), 128'h301C);
        check("stream_stall", 128'(a_stall_cnt), 128'd0);

        // Back-pressure fills the skid entry
        a_out_ready = 1'b0;
        drive_a(1'b1, 12'h0A1, 32'h4000);
        tick();
        drive_a(1'b1, 12'h0B2, 32'h4004);
        #1;
        check("bp_ready_main", 128'(a_in_ready), 128'd1);
        tick();
        check("bp_full_ready", 128'(a_in_ready), 128'd0);
        drive_a(1'b1, 12'h0C3, 32'h4008);
        repeat (4) tick();
        check("bp_hold_ready", 128'(a_in_ready), 128'd0);
        check("bp_hold_pc", 128'(a_out_pc), 128'h4000);
        check("bp_hold_ctrl", 128'(a_out_ctrl), 128'h0A1);
        check("bp_stall5", 128'(a_stall_cnt), 128'd5);
        a_out_ready = 1'b1;
        tick();
        check("bp_out_b_pc", 128'(a_out_pc), 128'h4004);
        check("bp_out_b_ctrl", 128'(a_out_ctrl), 128'h0B2);
        check("bp_out_b_data", a_out_data, mk_data(32'h4004));
        check("bp_ready_back", 128'(a_in_ready), 128'd1);
        tick();
        check("bp_out_c_pc", 128'(a_out_pc), 128'h4008);
        check("bp_out_c_valid", 128'(a_out_valid), 128'd1);
        drive_a(1'b0, 12'h000, 32'h0);
        tick();
        check("bp_empty", 128'(a_out_valid), 128'd0);
        check("bp_stall_kept", 128'(a_stall_cnt), 128'd5);

        // Flush with both entries held
        a_out_ready = 1'b0;
        drive_a(1'b1, 12'hFFF, 32'h5000);
        tick();
        drive_a(1'b1, 12'hFFF, 32'h5004);
        tick();
        drive_a(1'b1, 12'h555, 32'h5008);
        a_flush = 1'b1;
        tick();
        check("fl_valid", 128'(a_out_valid), 128'd0);
        check("fl_ctrl", 128'(a_out_ctrl), 128'd0);
        check("fl_in_ready", 128'(a_in_ready), 128'd1);
        check("fl_pc_held", 128'(a_out_pc), 128'h5000);
        check("fl_data_held", a_out_data, mk_data(32'h5000));
        a_flush = 1'b0;
        drive_a(1'b0, 12'h000, 32'h0);
        a_out_ready = 1'b1;
        tick();
        check("fl_after_valid", 128'(a_out_valid), 128'd0);

        // Flush beats a simultaneous accept
        a_out_ready = 1'b0;
        drive_a(1'b1, 12'h0F0, 32'h6000);
        tick();
        drive_a(1'b1, 12'h00F, 32'h6004);
        a_flush = 1'b1;
        #1;
        check("fl2_ready", 128'(a_in_ready), 128'd1);
        tick();
        check("fl2_valid", 128'(a_out_valid), 128'd0);
        check("fl2_pc", 128'(a_out_pc), 128'h6000);
        check("fl2_ctrl", 128'(a_out_ctrl), 128'd0);
        a_flush = 1'b0;
        drive_a(1'b0, 12'h000, 32'h0);
        tick();
        check("fl2_after_valid", 128'(a_out_valid), 128'd0);
        check("fl_stall", 128'(a_stall_cnt), 128'd8);

        // Single-entry stage: combinational ready and back-to-back replace
        drive_b(1'b1, 12'h111, 32'h7000);
        #1;
        check("ns_ready_empty", 128'(b_in_ready), 128'd1);
        tick();
        drive_b(1'b1, 12'h222, 32'h7004);
        #1;
        check("ns_ready_blocked", 128'(b_in_ready), 128'd0);
        check("ns_hold_pc", 128'(b_out_pc), 128'h7000);
        b_out_ready = 1'b1;
        #1;
        check("ns_ready_comb", 128'(b_in_ready), 128'd1);
        tick();
        check("ns_replace_pc", 128'(b_out_pc), 128'h7004);
        check("ns_replace_ctrl", 128'(b_out_ctrl), 128'h222);
        check("ns_replace_valid", 128'(b_out_valid), 128'd1);
        drive_b(1'b0, 12'h000, 32'h0);
        tick();
        check("ns_empty", 128'(b_out_valid), 128'd0);
        check("ns_bubble", 128'(b_out_ctrl), 128'd0);

        // Stall counter saturation, then asynchronous reset mid-stall
        b_out_ready = 1'b0;
        drive_b(1'b1, 12'h333, 32'h8000);
        tick();
        drive_b(1'b0, 12'h000, 32'h0);
        repeat (5) tick();
        check("sat_partial", 128'(b_stall_cnt), 128'd5);
        repeat (21) tick();
        check("sat_cnt", 128'(b_stall_cnt), 128'd15);
        check("sat_valid", 128'(b_out_valid), 128'd1);
        check("sat_pc", 128'(b_out_pc), 128'h8000);
        #3 reset = 1'b1;
        #1;
        check("ar_valid", 128'(b_out_valid), 128'd0);
        check("ar_ctrl", 128'(b_out_ctrl), 128'd0);
        check("ar_pc", 128'(b_out_pc), 128'h3004);
        check("ar_data", b_out_data, 128'd0);
        check("ar_stall", 128'(b_stall_cnt), 128'd0);
        check("ar_a_stall", 128'(a_stall_cnt), 128'd0);
        check("ar_a_pc", 128'(a_out_pc), 128'h3004);
        #2 reset = 1'b0;
        tick();
        check("ar_after_valid", 128'(b_out_valid), 128'd0);
        check("ar_after_ready", 128'(b_in_ready), 128'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
